// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 1-D streaming pooling stage.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: a full window of K samples summed without overflow.
    function automatic int sum_width(input int width, input int k);
        return width + $clog2(k);
    endfunction

endpackage

// File: rtl/pool_reduce_unit.sv
// Window accumulator: running max or running sum over one pooling window.
module pool_reduce_unit
    import pool_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int K     = 2,
    parameter  int MODE  = 0,
    localparam int AW    = sum_width(WIDTH, K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    first,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [AW-1:0]    acc_next,
    output logic signed [WIDTH-1:0] result
);

    localparam int         SHIFT  = $clog2(K);
    localparam pool_mode_e MODE_E = (MODE == 1) ? POOL_AVG : POOL_MAX;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] sample_ext;

    assign sample_ext = AW'(sample);

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        acc_next = sample_ext;
        if (!first) begin
            if (MODE_E == POOL_AVG) begin
                acc_next = acc_q + sample_ext;
            end else if (acc_q > sample_ext) begin
                acc_next = acc_q;
            end
        end
        acc_d = en ? acc_next : acc_q;
    end

    // Missing samples of a partial window simply never add in; the divisor stays K.
    assign result = (MODE_E == POOL_AVG) ? WIDTH'(acc_next >>> SHIFT) : WIDTH'(acc_next);

    // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pool_stream_1d.sv
// Streaming 1-D pooling stage: reduces each K-sample window of a LEN-sample vector to one output.
module pool_stream_1d
    import pool_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN   = 5,
    parameter int K     = 2,
    parameter int MODE  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    output logic signed [WIDTH-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y,
    output logic                    vec_done
);

    localparam int NOUT = (LEN + K - 1) / K;
    localparam int EW   = cnt_width(LEN);
    localparam int WW   = cnt_width(K);
    localparam int OW   = cnt_width(NOUT);
    localparam int AW   = sum_width(WIDTH, K);

    localparam logic [EW-1:0] ELEM_LAST = EW'(LEN - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(K - 1);
    localparam logic [OW-1:0] OUT_LAST  = OW'(NOUT - 1);

    localparam logic signed [AW-1:0] SAMPLE_MIN = AW'(-(2 ** (WIDTH - 1)));
    localparam logic signed [AW-1:0] SAMPLE_MAX = AW'(2 ** (WIDTH - 1) - 1);

    logic [EW-1:0]           elem_cnt_q, elem_cnt_d;
    logic [WW-1:0]           win_cnt_q, win_cnt_d;
    logic [OW-1:0]           out_cnt_q, out_cnt_d;
    logic                    m_valid_q, m_valid_d;
    logic signed [WIDTH-1:0] m_data_q, m_data_d;
    logic                    vec_done_q, vec_done_d;

    logic                    in_fire;
    logic                    out_fire;
    logic                    elem_last;
    logic                    win_first;
    logic                    close;
    logic signed [AW-1:0]    acc_next;
    logic signed [WIDTH-1:0] result;

    // A stalled output blocks the input, which freezes every counter and the accumulator.
    assign s_ready_x = !m_valid_q || m_ready_y;
    assign in_fire   = s_valid_x && s_ready_x;
    assign out_fire  = m_valid_q && m_ready_y;
    assign elem_last = (elem_cnt_q == ELEM_LAST);
    assign win_first = (win_cnt_q == '0);
    assign close     = in_fire && ((win_cnt_q == WIN_LAST) || elem_last);

    pool_reduce_unit #(
        .WIDTH (WIDTH),
        .K     (K),
        .MODE  (MODE)
    ) u_reduce (
        .clk      (clk),
        .reset    (reset),
        .first    (win_first),
        .en       (in_fire),
        .sample   (s_data_in_x),
        .acc_next (acc_next),
        .result   (result)
    );

    always_comb begin
        elem_cnt_d = elem_cnt_q;
        win_cnt_d  = win_cnt_q;
        out_cnt_d  = out_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        vec_done_d = 1'b0;

        if (in_fire) begin
            elem_cnt_d = elem_last ? '0 : elem_cnt_q + EW'(1);
            win_cnt_d  = close ? '0 : win_cnt_q + WW'(1);
        end

        if (out_fire) begin
            m_valid_d  = 1'b0;
            vec_done_d = (out_cnt_q == OUT_LAST);
            out_cnt_d  = vec_done_d ? '0 : out_cnt_q + OW'(1);
        end

        // A close in the same cycle as a transfer refills the register with no bubble.
        if (close) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt_q <= '0;
            win_cnt_q  <= '0;
            out_cnt_q  <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            vec_done_q <= 1'b0;
        end else begin
            elem_cnt_q <= elem_cnt_d;
            win_cnt_q  <= win_cnt_d;
            out_cnt_q  <= out_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            vec_done_q <= vec_done_d;
        end
    end

    assign m_valid_y    = m_valid_q;
    assign m_data_out_y = m_data_q;
    assign vec_done     = vec_done_q;

    // Max pooling only ever holds a raw sample, so its accumulator stays inside the sample range.
    a_max_in_range: assert property (@(posedge clk) disable iff (reset)
        (MODE == 1) || ((acc_next >= SAMPLE_MIN) && (acc_next <= SAMPLE_MAX)));

endmodule

// File: tb/tb_pool_stream_1d.sv
// Bench for pool_stream_1d: four parameterisations checked every cycle against a window-level model.
`timescale 1ns/1ps
module tb_pool_stream_1d;

    localparam int NI = 4;
    localparam int KS    [NI] = '{2, 2, 4, 4};
    localparam int MODES [NI] = '{0, 1, 0, 1};
    localparam int LENS  [NI] = '{5, 5, 5, 3};

    typedef struct {
        int val;
        bit last;
    } exp_t;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [NI-1:0]     s_valid_v = '0;
    logic [NI-1:0]     m_ready_v = '1;
    logic [NI-1:0][7:0] s_data_v = '0;
    logic [NI-1:0]     s_ready_v;
    logic [NI-1:0]     m_valid_v;
    logic [NI-1:0]     vec_done_v;
    logic [NI-1:0][7:0] m_data_v;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int got [NI][$];
    int done_cnt [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pooled value of the window holding the newest sample, straight from the pooling rules.
    function automatic int win_val(input int mode, input int k, input int vals[$]);
        int lo  = ((vals.size() - 1) / k) * k;
        int mx  = vals[lo];
        int sum = 0;
        int q;
        for (int i = lo; i < vals.size(); i++) begin
            sum += vals[i];
            if (vals[i] > mx) mx = vals[i];
        end
        if (mode == 0) return mx;
        q = sum / k;
        if (sum < 0 && q * k != sum) q -= 1;
        return q;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int KG = KS[g];
        localparam int MG = MODES[g];
        localparam int LG = LENS[g];

        int   vec [$];
        exp_t expq [$];
        bit   exp_done = 1'b0;

        pool_stream_1d #(
            .WIDTH (8),
            .LEN   (LG),
            .K     (KG),
            .MODE  (MG)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .s_data_in_x  (s_data_v[g]),
            .s_valid_x    (s_valid_v[g]),
            .s_ready_x    (s_ready_v[g]),
            .m_data_out_y (m_data_v[g]),
            .m_valid_y    (m_valid_v[g]),
            .m_ready_y    (m_ready_v[g]),
            .vec_done     (vec_done_v[g])
        );

        always @(negedge clk) begin : p_compare
            bit    exp_valid;
            bit    exp_ready;
            exp_t  e;
            string tag;
            tag = $sformatf("i%0d", g);
            if (reset) begin
                vec.delete();
                expq.delete();
                exp_done = 1'b0;
                check({tag, " reset s_ready"}, int'(s_ready_v[g]), 1);
                check({tag, " reset m_valid"}, int'(m_valid_v[g]), 0);
                check({tag, " reset vec_done"}, int'(vec_done_v[g]), 0);
                check({tag, " reset m_data"}, int'($signed(m_data_v[g])), 0);
            end else begin
                exp_valid = (expq.size() != 0);
                exp_ready = !exp_valid || m_ready_v[g];
                check({tag, " s_ready"}, int'(s_ready_v[g]), int'(exp_ready));
                check({tag, " m_valid"}, int'(m_valid_v[g]), int'(exp_valid));
                check({tag, " vec_done"}, int'(vec_done_v[g]), int'(exp_done));
                if (exp_valid) check({tag, " m_data"}, int'($signed(m_data_v[g])), expq[0].val);
                if (vec_done_v[g]) done_cnt[g]++;

                exp_done = 1'b0;
                if (exp_valid && m_ready_v[g]) begin
                    exp_done = expq[0].last;
                    got[g].push_back(int'($signed(m_data_v[g])));
                    void'(expq.pop_front());
                end
                if (s_valid_v[g] && exp_ready) begin
                    vec.push_back(int'($signed(s_data_v[g])));
                    if ((vec.size() % KG == 0) || (vec.size() == LG)) begin
                        e.val  = win_val(MG, KG, vec);
                        e.last = (vec.size() == LG);
                        expq.push_back(e);
                        if (e.last) vec.delete();
                    end
                end
            end
        end
    end

    task automatic send(input int g, input int v);
        int t = 0;
        s_valid_v[g] = 1'b1;
        s_data_v[g]  = 8'(v);
        @(negedge clk);
        while (!s_ready_v[g] && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready_v[g]) check($sformatf("i%0d send timeout", g), 0, 1);
        @(posedge clk);
        #1;
        s_valid_v[g] = 1'b0;
    endtask

    task automatic stream(input int g, input int vals[$]);
        foreach (vals[i]) send(g, vals[i]);
    endtask

    task automatic rand_stream(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            send(g, int'($urandom_range(0, 255)) - 128);
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_got(input string name, input int g, input int exp[$]);
        check({name, " count"}, got[g].size(), exp.size());
        foreach (exp[i]) begin
            if (i < got[g].size()) check($sformatf("%s[%0d]", name, i), got[g][i], exp[i]);
        end
        got[g].delete();
    endtask

    initial begin
        int q [$];
        int t0;
        foreach (done_cnt[i]) done_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("post-reset s_ready", int'(s_ready_v), 15);
        check("post-reset m_valid", int'(m_valid_v), 0);

        q = {3, -7, 10, 10, -2};
        stream(0, q);
        drain();
        q = {3, 10, -2};
        expect_got("max k2", 0, q);
        check("max k2 vec_done", done_cnt[0], 1);

        q = {-3, -4, 5, 6, 7, 0, 0, 0, 0, -1};
        stream(1, q);
        drain();
        q = {-4, 5, 3, 0, 0, -1};
        expect_got("avg k2", 1, q);
        check("avg k2 vec_done", done_cnt[1], 2);

        done_cnt[0] = 0;
        q = {3, -7, 10, 10, -2};
        fork
            stream(0, q);
            begin
                int t = 0;
                while (!(m_valid_v[0] && $signed(m_data_v[0]) == 10) && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                m_ready_v[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp s_ready", int'(s_ready_v[0]), 0);
                    check("bp hold data", int'($signed(m_data_v[0])), 10);
                end
                @(posedge clk);
                #1 m_ready_v[0] = 1'b1;
            end
        join
        drain();
        q = {3, 10, -2};
        expect_got("backpressure", 0, q);
        check("backpressure vec_done", done_cnt[0], 1);

        done_cnt[0] = 0;
        q = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        t0 = cyc;
        stream(0, q);
        check("b2b cycles", cyc - t0, 10);
        drain();
        q = {2, 4, 5, 7, 9, 10};
        expect_got("b2b", 0, q);
        check("b2b vec_done", done_cnt[0], 2);

        m_ready_v[0] = 1'b0;
        s_valid_v[0] = 1'b1;
        s_data_v[0]  = 8'(9);
        @(posedge clk);
        #1 s_data_v[0] = 8'(8);
        @(posedge clk);
        #1 s_data_v[0] = 8'(7);
        @(posedge clk);
        #1 check("pre-reset m_valid", int'(m_valid_v[0]), 1);
        #1 reset = 1'b1;
        #1;
        check("async reset m_valid", int'(m_valid_v[0]), 0);
        check("async reset s_ready", int'(s_ready_v[0]), 1);
        s_valid_v[0] = 1'b0;
        m_ready_v[0] = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        got[0].delete();
        q = {1, 2, 3, 4, 5};
        stream(0, q);
        drain();
        q = {2, 4, 5};
        expect_got("after reset", 0, q);

        q = {-128, -1, -5, -128, 127};
        stream(2, q);
        drain();
        q = {-1, 127};
        expect_got("max k4", 2, q);

        done_cnt[3] = 0;
        q = {7, -2, -8, 100, 100, 100};
        stream(3, q);
        drain();
        q = {-1, 75};
        expect_got("avg k4 len3", 3, q);
        check("avg k4 len3 vec_done", done_cnt[3], 2);

        done_cnt[0] = 0;
        done_cnt[2] = 0;
        fork
            rand_stream(0, 40);
            rand_stream(2, 40);
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    m_ready_v[0] = 1'($urandom_range(0, 1));
                    m_ready_v[2] = 1'($urandom_range(0, 1));
                end
                m_ready_v = '1;
            end
        join
        drain();
        check("rand i0 outputs", got[0].size(), 24);
        check("rand i2 outputs", got[2].size(), 16);
        check("rand i0 vec_done", done_cnt[0], 8);
        check("rand i2 vec_done", done_cnt[2], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got 1 timeout, expected 0");
        $fatal(1, "watchdog");
    end

endmodule
